matinv_gj: RTL and testbench

- Parametrised, sequential N×N fixed-point matrix inverter. Uses Gauss-Jordan elimination with partial pivoting on an augmented [A | I] array.
- Successor to the fixed-size matinvN blocks: any MATRIX_SIZE ≥ 2, configurable singularity threshold, row-swap pivoting, signed determinant output and sticky overflow flag.
- Sits between the navigation filter's covariance update and its gain computation. Fire-and-wait handshake.

---
 rtl/matinv_gj_if.sv | 24 ++
 rtl/matinv_gj.sv | 219 +++++++++++++++++++++
 tb/tb_matinv_gj.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/matinv_gj_if.sv
// matinv_gj_if: request/response bundle for the Gauss-Jordan matrix inverter.
//   master: drives start/matrix, observes ready/complete/inv/det/singular/overflow
//   slave : the inverter side
// matrix/inv pack element (r,c) at bits [(r*N+c)*DATA_WIDTH +: DATA_WIDTH].
interface matinv_gj_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int MATRIX_SIZE = 3
);
    localparam int MW = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;

    logic                  start;
    logic                  ready;
    logic                  complete;
    logic [MW-1:0]         matrix;
    logic [MW-1:0]         inv;
    logic [DATA_WIDTH-1:0] det;
    logic                  singular;
    logic                  overflow;

    modport master (output start, matrix,
                    input  ready, complete, inv, det, singular, overflow);
    modport slave  (input  start, matrix,
                    output ready, complete, inv, det, singular, overflow);
endinterface

// File: rtl/matinv_gj.sv
// matinv_gj: sequential N x N signed fixed-point inverter, Gauss-Jordan with
// partial pivoting on an augmented [A | I] working array.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   bus      : matinv_gj_if slave (start/ready/complete handshake, matrix in,
//              inv/det/singular/overflow out, valid while complete=1)
// Per column k: SEARCH (N) -> SWAP (1) -> RECIP (1 load + W+B divide steps)
//               -> NORM (1) -> ELIM (N).
module matinv_gj #(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 3,
    parameter int EPS         = 0
) (
    input  logic       clk,
    input  logic       rst,
    matinv_gj_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int B  = BIN_POS;
    localparam int N  = MATRIX_SIZE;
    localparam int RW = $clog2(N);
    localparam int QW = W + B;
    localparam int CW = $clog2(QW + 1);
    localparam logic [W-1:0]  ONE   = W'(1) << B;
    localparam logic [W-1:0]  DMIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  EPS_R = W'(EPS);
    localparam logic [QW-1:0] QMAX  = QW'(1) << (W-1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEARCH, S_SWAP, S_RECIP, S_NORM, S_ELIM, S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic signed [W-1:0]   r_a [N][2*N];
    logic [RW-1:0]         r_k, r_row, r_best_row;
    logic [W-1:0]          r_best_mag;
    logic [CW-1:0]         r_cnt;
    logic [W-1:0]          r_rem, r_div;
    logic [QW-1:0]         r_quo;
    logic                  r_qneg;
    logic signed [W-1:0]   r_det;
    logic                  r_ovf, r_sing;

    // Full-width product, floor shift by B, truncate; MSB flags lost bits.
    function automatic logic [W:0] f_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [2*W-1:0] ae, be, p;
        ae = {{W{a[W-1]}}, a};
        be = {{W{b[W-1]}}, b};
        p  = (ae * be) >>> B;
        return {p[2*W-1:W-1] != {(W+1){p[W-1]}}, p[W-1:0]};
    endfunction

    function automatic logic [W:0] f_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {a[W-1], a} - {b[W-1], b};
        return {d[W] ^ d[W-1], d[W-1:0]};
    endfunction

    // |x| as unsigned; the most negative value maps to 2^(W-1) correctly.
    function automatic logic [W-1:0] f_abs(input logic [W-1:0] a);
        return a[W-1] ? (~a + 1'b1) : a;
    endfunction

    // Pivot search: running best plus the row being scanned this cycle.
    logic [W-1:0]  w_mag, w_fin_mag;
    logic [RW-1:0] w_fin_row;
    logic          w_take, w_last_row;
    always_comb begin
        w_mag      = f_abs(r_a[r_row][r_k]);
        w_take     = (r_row >= r_k) && ((r_row == r_k) || (w_mag > r_best_mag));
        w_fin_mag  = w_take ? w_mag : r_best_mag;
        w_fin_row  = w_take ? r_row : r_best_row;
        w_last_row = (r_row == RW'(N-1));
    end

    // Divider step and signed reciprocal.
    logic [W:0]          w_rem_sh;
    logic                w_rem_ge, w_qovf;
    logic signed [W-1:0] w_q;
    logic [W:0]          w_dm;
    always_comb begin
        w_rem_sh = {r_rem, r_quo[QW-1]};
        w_rem_ge = (w_rem_sh >= {1'b0, r_div});
        w_q      = r_qneg ? -$signed(r_quo[W-1:0]) : $signed(r_quo[W-1:0]);
        w_qovf   = r_qneg ? (r_quo > QMAX) : (r_quo >= QMAX);
        w_dm     = f_mul(r_det, r_a[r_k][r_k]);
    end

    // Row operation shared by NORM (row k * q) and ELIM (row i - a(i,k)*row k).
    logic [W:0]          w_nm [2*N];
    logic [W:0]          w_pr [2*N];
    logic [W:0]          w_sb [2*N];
    logic signed [W-1:0] w_new [2*N];
    logic                w_ovf_op;
    always_comb begin
        w_ovf_op = 1'b0;
        for (int c = 0; c < 2*N; c++) begin
            w_nm[c] = f_mul(r_a[r_k][c], w_q);
            w_pr[c] = f_mul(r_a[r_row][r_k], r_a[r_k][c]);
            w_sb[c] = f_sub(r_a[r_row][c], w_pr[c][W-1:0]);
            if (r_state == S_NORM) begin
                w_new[c] = w_nm[c][W-1:0];
                w_ovf_op = w_ovf_op | w_nm[c][W];
            end else begin
                w_new[c] = w_sb[c][W-1:0];
                w_ovf_op = w_ovf_op | w_pr[c][W] | w_sb[c][W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.start) w_next = S_LOAD;
            S_LOAD:   w_next = S_SEARCH;
            S_SEARCH: if (w_last_row) w_next = (w_fin_mag <= EPS_R) ? S_DONE : S_SWAP;
            S_SWAP:   w_next = S_RECIP;
            S_RECIP:  if (r_cnt == CW'(QW)) w_next = S_NORM;
            S_NORM:   w_next = S_ELIM;
            S_ELIM:   if (w_last_row) w_next = (r_k == RW'(N-1)) ? S_DONE : S_SEARCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < 2*N; c++)
                    r_a[r][c] <= '0;
            r_k <= '0;   r_row <= '0;  r_best_row <= '0; r_best_mag <= '0;
            r_cnt <= '0; r_rem <= '0;  r_quo <= '0;      r_div <= '0;
            r_qneg <= 1'b0; r_det <= '0; r_ovf <= 1'b0;  r_sing <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (bus.start) begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++) begin
                            r_a[r][c]   <= bus.matrix[(r*N+c)*W +: W];
                            r_a[r][N+c] <= (r == c) ? ONE : '0;
                        end
                    r_det  <= ONE;
                    r_ovf  <= 1'b0;
                    r_sing <= 1'b0;
                end
                S_LOAD: begin
                    r_k   <= '0;
                    r_row <= '0;
                end
                S_SEARCH: begin
                    r_best_mag <= w_fin_mag;
                    r_best_row <= w_fin_row;
                    r_row      <= w_last_row ? '0 : r_row + 1'b1;
                    if (w_last_row && (w_fin_mag <= EPS_R)) r_sing <= 1'b1;
                end
                S_SWAP: begin
                    r_cnt <= '0;
                    if (r_best_row != r_k) begin
                        for (int c = 0; c < 2*N; c++) begin
                            r_a[r_k][c]        <= r_a[r_best_row][c];
                            r_a[r_best_row][c] <= r_a[r_k][c];
                        end
                        r_det <= -r_det;
                        if (r_det == DMIN) r_ovf <= 1'b1;
                    end
                end
                S_RECIP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '0) begin
                        // Load cycle: pivot is post-swap a(k,k); fold it into det.
                        r_div  <= f_abs(r_a[r_k][r_k]);
                        r_qneg <= r_a[r_k][r_k][W-1];
                        r_quo  <= QW'(1) << (2*B);
                        r_rem  <= '0;
                        r_det  <= w_dm[W-1:0];
                        r_ovf  <= r_ovf | w_dm[W];
                    end else begin
                        r_rem <= w_rem_ge ? W'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[W-1:0];
                        r_quo <= {r_quo[QW-2:0], w_rem_ge};
                    end
                end
                S_NORM: begin
                    for (int c = 0; c < 2*N; c++) r_a[r_k][c] <= w_new[c];
                    r_ovf <= r_ovf | w_ovf_op | w_qovf;
                end
                S_ELIM: begin
                    if (r_row != r_k) begin
                        for (int c = 0; c < 2*N; c++) r_a[r_row][c] <= w_new[c];
                        r_ovf <= r_ovf | w_ovf_op;
                    end
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                    if (w_last_row) r_k <= r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Results read straight from the working array; singular forces zeros.
    logic [N*N*W-1:0] w_inv;
    always_comb begin
        w_inv = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                w_inv[(r*N+c)*W +: W] = r_sing ? '0 : r_a[r][N+c];
    end

    assign bus.inv      = w_inv;
    assign bus.det      = r_sing ? '0 : r_det;
    assign bus.singular = r_sing;
    assign bus.overflow = r_ovf;
    assign bus.ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign bus.complete = (r_state == S_DONE);
endmodule

// File: tb/tb_matinv_gj.sv
module tb_matinv_gj;
    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    matinv_gj_if #(.DATA_WIDTH(16), .MATRIX_SIZE(3)) if3 ();
    matinv_gj_if #(.DATA_WIDTH(16), .MATRIX_SIZE(2)) if2 ();
    matinv_gj_if #(.DATA_WIDTH(16), .MATRIX_SIZE(2)) if2e ();

    matinv_gj #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(3), .EPS(0)) dut3  (.clk(clk), .rst(rst), .bus(if3));
    matinv_gj #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(2), .EPS(0)) dut2  (.clk(clk), .rst(rst), .bus(if2));
    matinv_gj #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(2), .EPS(4)) dut2e (.clk(clk), .rst(rst), .bus(if2e));

    function automatic logic [143:0] m3(input logic [15:0] a00, a01, a02, a10, a11, a12, a20, a21, a22);
        return {a22, a21, a20, a12, a11, a10, a02, a01, a00};
    endfunction

    function automatic logic [63:0] m2(input logic [15:0] a00, a01, a10, a11);
        return {a11, a10, a01, a00};
    endfunction

    // Pulse start on the selected DUT and count cycles until complete
    // (the start cycle is cycle 0). Stops at the budget if complete never rises.
    task automatic run(input int sel, input logic [143:0] m, output int cyc);
        logic done;
        @(negedge clk);
        case (sel)
            0: begin if3.matrix  = m;        if3.start  = 1'b1; end
            1: begin if2.matrix  = m[63:0];  if2.start  = 1'b1; end
            default: begin if2e.matrix = m[63:0]; if2e.start = 1'b1; end
        endcase
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if3.start = 1'b0; if2.start = 1'b0; if2e.start = 1'b0;
            case (sel)
                0: done = if3.complete;
                1: done = if2.complete;
                default: done = if2e.complete;
            endcase
        end
    endtask

    task automatic test_reset;
        vecs++; if (if3.ready !== 1'b1)     begin errs++; $display("FAIL reset_ready: got %b want 1", if3.ready); end
        vecs++; if (if3.complete !== 1'b0)  begin errs++; $display("FAIL reset_complete: got %b want 0", if3.complete); end
        vecs++; if (if3.inv !== 144'd0)     begin errs++; $display("FAIL reset_inv: got %h want 0", if3.inv); end
        vecs++; if (if3.det !== 16'h0000)   begin errs++; $display("FAIL reset_det: got %h want 0000", if3.det); end
        vecs++; if (if3.singular !== 1'b0)  begin errs++; $display("FAIL reset_singular: got %b want 0", if3.singular); end
        vecs++; if (if3.overflow !== 1'b0)  begin errs++; $display("FAIL reset_overflow: got %b want 0", if3.overflow); end
        vecs++; if (if2.ready !== 1'b1)     begin errs++; $display("FAIL reset_ready2: got %b want 1", if2.ready); end
    endtask

    task automatic test_identity;
        int cyc;
        logic [143:0] id3;
        id3 = m3(16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0, 16'h0100);
        run(0, id3, cyc);
        vecs++; if (cyc !== 101)            begin errs++; $display("FAIL ident_latency: got %0d want 101", cyc); end
        vecs++; if (if3.inv !== id3)        begin errs++; $display("FAIL ident_inv: got %h want %h", if3.inv, id3); end
        vecs++; if (if3.det !== 16'h0100)   begin errs++; $display("FAIL ident_det: got %h want 0100", if3.det); end
        vecs++; if (if3.singular !== 1'b0)  begin errs++; $display("FAIL ident_singular: got %b want 0", if3.singular); end
        vecs++; if (if3.overflow !== 1'b0)  begin errs++; $display("FAIL ident_overflow: got %b want 0", if3.overflow); end
        vecs++; if (if3.ready !== 1'b1)     begin errs++; $display("FAIL ident_ready: got %b want 1", if3.ready); end
    endtask

    task automatic test_diag;
        int cyc;
        run(1, {80'd0, m2(16'h0200, 0, 0, 16'h0400)}, cyc);
        vecs++; if (cyc !== 64)                           begin errs++; $display("FAIL diag_latency: got %0d want 64", cyc); end
        vecs++; if (if2.inv !== m2(16'h0080, 0, 0, 16'h0040)) begin errs++; $display("FAIL diag_inv: got %h want 0040000000000080", if2.inv); end
        vecs++; if (if2.det !== 16'h0800)                 begin errs++; $display("FAIL diag_det: got %h want 0800", if2.det); end
        vecs++; if (if2.overflow !== 1'b0)                begin errs++; $display("FAIL diag_overflow: got %b want 0", if2.overflow); end
    endtask

    task automatic test_swap;
        int cyc;
        logic [63:0] p;
        p = m2(0, 16'h0100, 16'h0100, 0);
        run(1, {80'd0, p}, cyc);
        vecs++; if (if2.inv !== p)          begin errs++; $display("FAIL swap_inv: got %h want %h", if2.inv, p); end
        vecs++; if (if2.det !== 16'hFF00)   begin errs++; $display("FAIL swap_det: got %h want ff00", if2.det); end
        vecs++; if (if2.singular !== 1'b0)  begin errs++; $display("FAIL swap_singular: got %b want 0", if2.singular); end
    endtask

    task automatic test_singular;
        int cyc;
        logic [63:0] near;
        run(1, {80'd0, m2(16'h0100, 16'h0200, 16'h0200, 16'h0400)}, cyc);
        vecs++; if (cyc !== 35)             begin errs++; $display("FAIL sing_latency: got %0d want 35", cyc); end
        vecs++; if (if2.singular !== 1'b1)  begin errs++; $display("FAIL sing_flag: got %b want 1", if2.singular); end
        vecs++; if (if2.inv !== 64'd0)      begin errs++; $display("FAIL sing_inv: got %h want 0", if2.inv); end
        vecs++; if (if2.det !== 16'h0000)   begin errs++; $display("FAIL sing_det: got %h want 0000", if2.det); end
        // 4.01 -> raw 0x0403: residual pivot is -1 raw, singular only with EPS=4.
        near = m2(16'h0100, 16'h0200, 16'h0200, 16'h0403);
        run(2, {80'd0, near}, cyc);
        vecs++; if (cyc !== 35)             begin errs++; $display("FAIL eps_latency: got %0d want 35", cyc); end
        vecs++; if (if2e.singular !== 1'b1) begin errs++; $display("FAIL eps_singular: got %b want 1", if2e.singular); end
        run(1, {80'd0, near}, cyc);
        vecs++; if (if2.singular !== 1'b0)  begin errs++; $display("FAIL eps0_singular: got %b want 0", if2.singular); end
    endtask

    task automatic test_overflow;
        int cyc;
        run(1, {80'd0, m2(16'h0010, 0, 0, 16'h0010)}, cyc);
        vecs++; if (if2.inv !== m2(16'h1000, 0, 0, 16'h1000)) begin errs++; $display("FAIL small_inv: got %h want 1000000000001000", if2.inv); end
        vecs++; if (if2.det !== 16'h0001)   begin errs++; $display("FAIL small_det: got %h want 0001", if2.det); end
        vecs++; if (if2.overflow !== 1'b0)  begin errs++; $display("FAIL small_overflow: got %b want 0", if2.overflow); end
        run(1, {80'd0, m2(16'h0001, 0, 0, 16'h0001)}, cyc);
        vecs++; if (if2.overflow !== 1'b1)  begin errs++; $display("FAIL tiny_overflow: got %b want 1", if2.overflow); end
        vecs++; if (if2.singular !== 1'b0)  begin errs++; $display("FAIL tiny_singular: got %b want 0", if2.singular); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        @(negedge clk);
        if2.matrix = m2(16'h0200, 0, 0, 16'h0400);
        if2.start  = 1'b1;
        @(posedge clk); #1;
        if2.start = 1'b0;
        cyc = 1;
        vecs++; if (if2.complete !== 1'b0)  begin errs++; $display("FAIL b2b_complete_drop: got %b want 0", if2.complete); end
        vecs++; if (if2.ready !== 1'b0)     begin errs++; $display("FAIL b2b_ready_drop: got %b want 0", if2.ready); end
        while (!if2.complete && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        vecs++; if (cyc !== 64)             begin errs++; $display("FAIL b2b_latency: got %0d want 64", cyc); end
        vecs++; if (if2.det !== 16'h0800)   begin errs++; $display("FAIL b2b_det: got %h want 0800", if2.det); end
    endtask

    task automatic test_busy_and_reset;
        int cyc;
        logic [143:0] p, pi, id3;
        p   = m3(0, 16'h0100, 0, 16'h0100, 0, 0, 0, 0, 16'h0200);
        pi  = m3(0, 16'h0100, 0, 16'h0100, 0, 0, 0, 0, 16'h0080);
        id3 = m3(16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0, 16'h0100);
        // Extra starts with a different matrix while busy must be ignored.
        @(negedge clk);
        if3.matrix = p;
        if3.start  = 1'b1;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 5) if3.matrix = id3;
            if3.start = (cyc == 5 || cyc == 40);
            if (if3.complete) break;
        end
        if3.start = 1'b0;
        vecs++; if (cyc !== 101)            begin errs++; $display("FAIL busy_latency: got %0d want 101", cyc); end
        vecs++; if (if3.inv !== pi)         begin errs++; $display("FAIL busy_inv: got %h want %h", if3.inv, pi); end
        vecs++; if (if3.det !== 16'hFE00)   begin errs++; $display("FAIL busy_det: got %h want fe00", if3.det); end
        // Reset during column-0 elimination.
        @(negedge clk);
        if3.matrix = id3;
        if3.start  = 1'b1;
        cyc = 0;
        while (cyc < 32) begin
            @(posedge clk); #1;
            cyc++;
            if3.start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vecs++; if (if3.ready !== 1'b1)     begin errs++; $display("FAIL rst_ready: got %b want 1", if3.ready); end
        vecs++; if (if3.complete !== 1'b0)  begin errs++; $display("FAIL rst_complete: got %b want 0", if3.complete); end
        vecs++; if (if3.inv !== 144'd0)     begin errs++; $display("FAIL rst_inv: got %h want 0", if3.inv); end
        vecs++; if (if3.det !== 16'h0000)   begin errs++; $display("FAIL rst_det: got %h want 0000", if3.det); end
        run(0, p, cyc);
        vecs++; if (cyc !== 101)            begin errs++; $display("FAIL post_rst_latency: got %0d want 101", cyc); end
        vecs++; if (if3.inv !== pi)         begin errs++; $display("FAIL post_rst_inv: got %h want %h", if3.inv, pi); end
        vecs++; if (if3.det !== 16'hFE00)   begin errs++; $display("FAIL post_rst_det: got %h want fe00", if3.det); end
    endtask

    initial begin
        rst = 1'b1;
        if3.start = 1'b0;  if3.matrix = '0;
        if2.start = 1'b0;  if2.matrix = '0;
        if2e.start = 1'b0; if2e.matrix = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_identity;
        test_diag;
        test_swap;
        test_singular;
        test_overflow;
        test_back_to_back;
        test_busy_and_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
